// File: rtl/if_imem_rx_if.sv
// Handshake bundle for if_imem_rx: address in, memory read port, instruction out to decode.
// The id_misalign wire exists only when IMEM_MISALIGN_CHK_EN is defined.
interface if_imem_rx_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] rx_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [DATA_W-1:0] id_instr;
`ifdef IMEM_MISALIGN_CHK_EN
  logic              id_misalign;
`endif

  // Fetch-unit side.
  modport slave (
    input  rx_valid, rx_addr, mem_rdata, flush, id_ready,
    output rx_ready, mem_req, mem_addr, id_valid, id_pc, id_instr
`ifdef IMEM_MISALIGN_CHK_EN
    , id_misalign
`endif
  );

  // Environment side: address generator, instruction memory and decode.
  modport master (
    output rx_valid, rx_addr, mem_rdata, flush, id_ready,
    input  rx_ready, mem_req, mem_addr, id_valid, id_pc, id_instr
`ifdef IMEM_MISALIGN_CHK_EN
    , id_misalign
`endif
  );
endinterface

// File: rtl/if_imem_rx.sv
// Fetch-stage consumer: issues addresses to a 1-cycle imem, buffers {pc, instr} for decode.
// Optional feature macro: IMEM_MISALIGN_CHK_EN (per-entry misalignment flag, word-aligned reads).
module if_imem_rx #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  if_imem_rx_if.slave   imem
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0]  count_q,    count_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];
`ifdef IMEM_MISALIGN_CHK_EN
  logic              mis_q,      mis_d;
  logic              mis_mem   [FIFO_DEPTH];
`endif

  logic [SUM_W-1:0]  credit_use_c;
  logic              rx_ready_c;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;

  // Credit check counts the in-flight read so its return always finds a free slot.
  always_comb begin
    credit_use_c = SUM_W'(count_q) + SUM_W'(inflight_q);
    rx_ready_c   = !imem.flush && (credit_use_c < SUM_W'(FIFO_DEPTH));
    accept_c     = imem.rx_valid && rx_ready_c;
    push_c       = inflight_q && !imem.flush;
    pop_c        = (count_q != '0) && imem.id_ready && !imem.flush;
  end

  assign imem.rx_ready = rx_ready_c;
  assign imem.mem_req  = accept_c;
`ifdef IMEM_MISALIGN_CHK_EN
  assign imem.mem_addr = {imem.rx_addr[ADDR_W-1:2], 2'b00};
`else
  assign imem.mem_addr = imem.rx_addr;
`endif

  always_comb begin
    count_d    = count_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_d       = pc_q;
`ifdef IMEM_MISALIGN_CHK_EN
    mis_d      = mis_q;
`endif
    if (imem.flush) begin
      count_d    = '0;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      inflight_d = accept_c;
      if (accept_c) begin
        pc_d = imem.rx_addr;
`ifdef IMEM_MISALIGN_CHK_EN
        mis_d = (imem.rx_addr[1:0] != 2'b00);
`endif
      end
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pc_q       <= '0;
`ifdef IMEM_MISALIGN_CHK_EN
      mis_q      <= 1'b0;
`endif
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
`ifdef IMEM_MISALIGN_CHK_EN
        mis_mem[i]   <= 1'b0;
`endif
      end
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_q       <= pc_d;
`ifdef IMEM_MISALIGN_CHK_EN
      mis_q      <= mis_d;
`endif
      // Read data is valid exactly one cycle after the accepted request.
      if (push_c) begin
        pc_mem[wr_ptr_q]    <= pc_q;
        instr_mem[wr_ptr_q] <= imem.mem_rdata;
`ifdef IMEM_MISALIGN_CHK_EN
        mis_mem[wr_ptr_q]   <= mis_q;
`endif
      end
    end
  end

  assign imem.id_valid    = (count_q != '0);
  assign imem.id_pc       = pc_mem[rd_ptr_q];
  assign imem.id_instr    = instr_mem[rd_ptr_q];
`ifdef IMEM_MISALIGN_CHK_EN
  assign imem.id_misalign = mis_mem[rd_ptr_q];
`endif

endmodule
